// File: rtl/tournament_issue_ctrl_if.sv
// Bundle of request, tournament and grant signals between the issue stage
// and its environment (units, tournament, grant consumer).
interface tournament_issue_ctrl_if #(
    parameter int NUM_UNITS = 16,
    parameter int WIDTH_VAL = 8,
    parameter int WIDTH_IDX = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
);
    logic [NUM_UNITS-1:0]                I_Req;
    logic [NUM_UNITS-1:0][WIDTH_VAL-1:0] I_Value;
    logic [NUM_UNITS-1:0]                O_Ready;
    logic [NUM_UNITS-1:0][WIDTH_VAL:0]   O_Entry;
    logic [NUM_UNITS-1:0]                I_Win_Valid;
    logic [WIDTH_VAL:0]                  I_Win_Entry;
    logic                                O_Grant_Valid;
    logic [WIDTH_IDX-1:0]                O_Grant_Index;
    logic [WIDTH_VAL-1:0]                O_Grant_Value;
    logic                                I_Grant_Ready;
    logic                                O_Err;

    modport slave (
        input  I_Req, I_Value, I_Win_Valid, I_Win_Entry, I_Grant_Ready,
        output O_Ready, O_Entry, O_Grant_Valid, O_Grant_Index, O_Grant_Value, O_Err
    );

    modport master (
        output I_Req, I_Value, I_Win_Valid, I_Win_Entry, I_Grant_Ready,
        input  O_Ready, O_Entry, O_Grant_Valid, O_Grant_Index, O_Grant_Value, O_Err
    );
endinterface

// File: rtl/tournament_issue_ctrl.sv
// Request-holding and grant-issue stage around a combinational largest-value
// tournament: holds one request per unit, ages pending slots, issues one grant at a time.
module tournament_issue_ctrl #(
    parameter int NUM_UNITS  = 16,
    parameter int WIDTH_VAL  = 8,
    parameter int AGE_PERIOD = 64,
    parameter int WIDTH_IDX  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    tournament_issue_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SELECT, ISSUE} state_t;

    localparam int AGE_W = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;

    state_t                              state_reg, state_next;
    logic [NUM_UNITS-1:0]                pending_reg, pending_next;
    logic [NUM_UNITS-1:0][WIDTH_VAL-1:0] value_reg, value_next;
    logic                                grant_valid_reg, grant_valid_next;
    logic [WIDTH_IDX-1:0]                grant_idx_reg, grant_idx_next;
    logic [WIDTH_VAL-1:0]                grant_val_reg, grant_val_next;
    logic                                err_reg, err_next;

    logic [NUM_UNITS-1:0] cand;
    logic [NUM_UNITS-1:0] load;
    logic [WIDTH_IDX-1:0] win_idx;
    logic                 win_found;
    logic                 sel_fire;
    logic                 age_tick;

    // Aging tick generator; AGE_PERIOD of 0 removes the counter entirely.
    generate
        if (AGE_PERIOD == 0) begin : g_no_age
            assign age_tick = 1'b0;
        end else begin : g_age
            logic [AGE_W-1:0] age_cnt_reg;
            always_ff @(posedge clock or negedge reset) begin
                if (!reset)
                    age_cnt_reg <= '0;
                else if (age_cnt_reg == AGE_W'(AGE_PERIOD - 1))
                    age_cnt_reg <= '0;
                else
                    age_cnt_reg <= age_cnt_reg + 1'b1;
            end
            assign age_tick = (age_cnt_reg == AGE_W'(AGE_PERIOD - 1));
        end
    endgenerate

    // Tie-break: lowest index among flagged slots that are actually pending.
    assign cand      = bus.I_Win_Valid & pending_reg;
    assign win_found = |cand;
    assign sel_fire  = (state_reg == SELECT) && win_found;
    assign load      = bus.I_Req & ~pending_reg;

    always_comb begin
        win_idx = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (cand[i])
                win_idx = WIDTH_IDX'(i);
        end
    end

    // Clear beats aging; a cleared slot also drops its value so empty entries read as zero.
    generate
        for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_slot
            logic clr;
            logic age_inc;
            assign clr     = sel_fire && (win_idx == WIDTH_IDX'(gi));
            assign age_inc = age_tick && pending_reg[gi] && (value_reg[gi] != {WIDTH_VAL{1'b1}});
            assign pending_next[gi] = clr ? 1'b0 : (load[gi] ? 1'b1 : pending_reg[gi]);
            assign value_next[gi]   = clr      ? '0 :
                                      load[gi] ? bus.I_Value[gi] :
                                      age_inc  ? value_reg[gi] + 1'b1 :
                                                 value_reg[gi];
            assign bus.O_Entry[gi]  = {pending_reg[gi], value_reg[gi]};
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        grant_valid_next = grant_valid_reg;
        grant_idx_next   = grant_idx_reg;
        grant_val_next   = grant_val_reg;
        err_next         = err_reg;
        case (state_reg)
            IDLE: begin
                if (|pending_reg)
                    state_next = SELECT;
            end
            SELECT: begin
                if (win_found) begin
                    grant_valid_next = 1'b1;
                    grant_idx_next   = win_idx;
                    grant_val_next   = value_reg[win_idx];
                    state_next       = ISSUE;
                end else begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end
            end
            ISSUE: begin
                if (bus.I_Grant_Ready) begin
                    grant_valid_next = 1'b0;
                    state_next       = ((|pending_reg) || (|load)) ? SELECT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            pending_reg     <= '0;
            value_reg       <= '0;
            grant_valid_reg <= 1'b0;
            grant_idx_reg   <= '0;
            grant_val_reg   <= '0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pending_reg     <= pending_next;
            value_reg       <= value_next;
            grant_valid_reg <= grant_valid_next;
            grant_idx_reg   <= grant_idx_next;
            grant_val_reg   <= grant_val_next;
            err_reg         <= err_next;
        end
    end

    assign bus.O_Ready       = ~pending_reg;
    assign bus.O_Grant_Valid = grant_valid_reg;
    assign bus.O_Grant_Index = grant_idx_reg;
    assign bus.O_Grant_Value = grant_val_reg;
    assign bus.O_Err         = err_reg;
endmodule
